// File: rtl/nios_cpu_pio_mini_arb.sv
`timescale 1ns/1ps
// nios_cpu_pio_mini_arb
//
// Purpose:
//   Shares one 8-bit mini PIO output register between N_REQ local requesters.
//   Each requester posts one operation (WRITE, SET bits, CLEAR bits, READ).
//   A round-robin winner is issued as a single-cycle Avalon-MM transfer on the
//   PIO s1 slave, then acknowledged with a one-cycle pulse.
//   Every operation takes three cycles: IDLE -> ISSUE -> ACK.
//
// Ports:
//   clk          in   1        single clock, rising edge
//   reset_n      in   1        synchronous reset, active low
//   req          in   N_REQ    req[i]: requester i has an operation pending
//   req_op       in   2*N_REQ  op of requester i at [2i+1:2i]
//                              (00 WRITE, 01 SET, 10 CLEAR, 11 READ)
//   req_data     in   8*N_REQ  data or mask of requester i at [8i+7:8i]
//   ack          out  N_REQ    one-cycle pulse: op of requester i completed
//   rdata        out  8        PIO data captured by the last READ
//   busy         out  1        high whenever the sequencer is not idle
//   m_address    out  3        PIO address
//   m_chipselect out  1        PIO chipselect
//   m_write_n    out  1        PIO write_n
//   m_writedata  out  32       PIO writedata, {24'b0, data}
//   m_readdata   in   32       PIO readdata (combinational); bits [7:0] used
module nios_cpu_pio_mini_arb #(
    parameter int         N_REQ     = 4,
    parameter logic [2:0] ADDR_DATA = 3'd0,
    parameter logic [2:0] ADDR_SET  = 3'd4,
    parameter logic [2:0] ADDR_CLR  = 3'd5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_op,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic [2:0]           m_address,
    output logic                 m_chipselect,
    output logic                 m_write_n,
    output logic [31:0]          m_writedata,
    input  logic [31:0]          m_readdata
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    state_e             state_q;
    logic [IW-1:0]      last_grant_q;
    logic [IW-1:0]      winner_q;
    op_e                op_q;
    logic [N_REQ-1:0]   ack_q;
    logic [7:0]         rdata_q;
    logic               busy_q;
    logic [2:0]         m_address_q;
    logic               m_chipselect_q;
    logic               m_write_n_q;
    logic [7:0]         m_wdata_q;

    logic               grant_vld_d;
    logic [IW-1:0]      grant_d;
    logic [IW-1:0]      cand;
    op_e                grant_op_d;
    logic [7:0]         grant_data_d;

    // Only the low byte of the PIO read bus carries data.
    logic               unused_readdata_hi;
    assign unused_readdata_hi = ^m_readdata[31:8];

    function automatic logic [2:0] op_addr(input op_e op);
        case (op)
            OP_SET:   return ADDR_SET;
            OP_CLEAR: return ADDR_CLR;
            default:  return ADDR_DATA;   // WRITE and READ both target the data register
        endcase
    endfunction

    // Round-robin pick: scan last_grant+1, +2, ... so the most recently served
    // requester is considered last.
    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise a
        // path that skips an assignment infers a latch.
        grant_vld_d  = 1'b0;
        grant_d      = '0;
        cand         = '0;
        grant_op_d   = OP_WRITE;
        grant_data_d = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last_grant_q) + k) % N_REQ);
            if (!grant_vld_d && req[cand]) begin
                grant_vld_d = 1'b1;
                grant_d     = cand;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_d == IW'(i)) begin
                grant_op_d   = op_e'(req_op[2*i +: 2]);
                grant_data_d = req_data[8*i +: 8];
            end
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= IW'(N_REQ - 1);   // requester 0 wins first after reset
            winner_q       <= '0;
            op_q           <= OP_WRITE;
            ack_q          <= '0;
            rdata_q        <= '0;
            busy_q         <= 1'b0;
            m_address_q    <= '0;
            m_chipselect_q <= 1'b0;
            m_write_n_q    <= 1'b1;
            m_wdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_d) begin
                        winner_q       <= grant_d;
                        op_q           <= grant_op_d;
                        busy_q         <= 1'b1;
                        m_chipselect_q <= 1'b1;
                        m_address_q    <= op_addr(grant_op_d);
                        m_write_n_q    <= (grant_op_d == OP_READ);
                        // A READ leaves the write bus holding its previous value.
                        if (grant_op_d != OP_READ) begin
                            m_wdata_q <= grant_data_d;
                        end
                        state_q        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (op_q == OP_READ) begin
                        rdata_q <= m_readdata[7:0];
                    end
                    m_chipselect_q <= 1'b0;
                    m_write_n_q    <= 1'b1;
                    ack_q          <= N_REQ'(1) << winner_q;
                    state_q        <= ST_ACK;
                end
                ST_ACK: begin
                    ack_q        <= '0;
                    last_grant_q <= winner_q;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack          = ack_q;
    assign rdata        = rdata_q;
    assign busy         = busy_q;
    assign m_address    = m_address_q;
    assign m_chipselect = m_chipselect_q;
    assign m_write_n    = m_write_n_q;
    assign m_writedata  = {24'b0, m_wdata_q};

endmodule

// File: tb/tb_nios_cpu_pio_mini_arb.sv
`timescale 1ns/1ps
// tb_nios_cpu_pio_mini_arb
//
// Purpose:
//   Drives directed operations into nios_cpu_pio_mini_arb with a behavioural
//   PIO attached. Expected bus transfers and acks are queued as stimulus is
//   issued; a negedge monitor pops and compares whenever the DUT presents a
//   chipselect or an ack.
//
// Ports: none (top-level bench).
module tb_nios_cpu_pio_mini_arb;

    localparam int N_REQ = 4;
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [N_REQ-1:0]     req;
    logic [2*N_REQ-1:0]   req_op;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     ack;
    logic [7:0]           rdata;
    logic                 busy;
    logic [2:0]           m_address;
    logic                 m_chipselect;
    logic                 m_write_n;
    logic [31:0]          m_writedata;
    logic [31:0]          m_readdata;

    nios_cpu_pio_mini_arb #(.N_REQ(N_REQ)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_op       (req_op),
        .req_data     (req_data),
        .ack          (ack),
        .rdata        (rdata),
        .busy         (busy),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural mini PIO: data at 0, set at 4, clear at 5; not reset by reset_n.
    logic [7:0] pio_out = 8'h00;
    assign m_readdata = (m_address == 3'd0) ? {24'h0, pio_out} : 32'h0;

    always @(posedge clk) begin
        if (m_chipselect && !m_write_n) begin
            case (m_address)
                3'd0:    pio_out <= m_writedata[7:0];
                3'd4:    pio_out <= pio_out | m_writedata[7:0];
                3'd5:    pio_out <= pio_out & ~m_writedata[7:0];
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [2:0] addr;
        logic       wr_n;
        logic [7:0] wdata;
        bit         chk_wdata;
    } bus_t;

    typedef struct {
        int         idx;
        logic [7:0] rdata;
        logic [7:0] outp;
    } ack_t;

    bus_t bus_q[$];
    ack_t ack_q[$];
    bus_t mon_b;
    ack_t mon_a;

    int vectors     = 0;
    int miscompares = 0;
    int ack_count   = 0;
    logic [7:0] model_out = 8'h00;
    logic [7:0] model_rd  = 8'h00;
    logic       prev_cs   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each chipselect and each ack against the queues.
    always @(negedge clk) begin
        if (m_chipselect === 1'b1) begin
            check("cs_single_cycle", 32'(prev_cs), 32'd0);
            check("busy_during_issue", 32'(busy), 32'd1);
            if (bus_q.size() == 0) begin
                check("unexpected_cs", 32'(m_address), 32'hFFFF_FFFF);
            end else begin
                mon_b = bus_q.pop_front();
                check("bus_addr", 32'(m_address), 32'(mon_b.addr));
                check("bus_wr_n", 32'(m_write_n), 32'(mon_b.wr_n));
                if (mon_b.chk_wdata) begin
                    check("bus_wdata", m_writedata, {24'h0, mon_b.wdata});
                end
            end
        end
        if ((ack !== '0) && (ack !== 'x)) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                mon_a = ack_q.pop_front();
                check("ack_onehot", 32'(ack), 32'(1 << mon_a.idx));
                check("ack_rdata", 32'(rdata), 32'(mon_a.rdata));
                check("ack_out_port", 32'(pio_out), 32'(mon_a.outp));
                check("ack_cs_low", 32'(m_chipselect), 32'd0);
                check("ack_wr_n_high", 32'(m_write_n), 32'd1);
            end
            ack_count++;
        end
        prev_cs = (m_chipselect === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic [1:0] op, input logic [7:0] d);
        req[i]           = 1'b1;
        req_op[2*i +: 2] = op;
        req_data[8*i +: 8] = d;
    endtask

    task automatic drop(input int i);
        req[i] = 1'b0;
    endtask

    // Queue the bus transfer of one op and update the PIO image it produces.
    task automatic exp_bus(input logic [1:0] op, input logic [7:0] d);
        bus_t b;
        case (op)
            OP_WRITE: begin model_out = d;               b.addr = 3'd0; end
            OP_SET:   begin model_out = model_out | d;   b.addr = 3'd4; end
            OP_CLEAR: begin model_out = model_out & ~d;  b.addr = 3'd5; end
            default:  begin model_rd  = model_out;       b.addr = 3'd0; end
        endcase
        b.wr_n      = (op == OP_READ);
        b.wdata     = d;
        b.chk_wdata = (op != OP_READ);
        bus_q.push_back(b);
    endtask

    task automatic exp_op(input int idx, input logic [1:0] op, input logic [7:0] d);
        ack_t a;
        exp_bus(op, d);
        a.idx   = idx;
        a.rdata = model_rd;
        a.outp  = model_out;
        ack_q.push_back(a);
    endtask

    task automatic wait_acks(input int target, input string name);
        int cyc = 0;
        while (ack_count < target && cyc < 60) begin
            tick();
            cyc++;
        end
        check(name, 32'(ack_count), 32'(target));
    endtask

    task automatic do_op(input int i, input logic [1:0] op, input logic [7:0] d);
        int target;
        target = ack_count + 1;
        post(i, op, d);
        exp_op(i, op, d);
        wait_acks(target, "single_op_done");
        drop(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        reset_n  = 1'b0;
        req      = '0;
        req_op   = '0;
        req_data = '0;

        // Reset state
        tick();
        tick();
        check("rst_ack",   32'(ack),          32'd0);
        check("rst_rdata", 32'(rdata),        32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_cs",    32'(m_chipselect), 32'd0);
        check("rst_wr_n",  32'(m_write_n),    32'd1);
        check("rst_addr",  32'(m_address),    32'd0);
        check("rst_wdata", m_writedata,       32'd0);
        reset_n = 1'b1;
        tick();

        // WRITE 0xA5 from requester 0, with cycle-exact latency checks
        target = ack_count + 1;
        post(0, OP_WRITE, 8'hA5);
        exp_op(0, OP_WRITE, 8'hA5);
        tick();
        check("t2_cs",    32'(m_chipselect), 32'd1);
        check("t2_addr",  32'(m_address),    32'd0);
        check("t2_wr_n",  32'(m_write_n),    32'd0);
        check("t2_wdata", m_writedata,       32'h0000_00A5);
        check("t2_busy",  32'(busy),         32'd1);
        tick();
        check("t2_ack",   32'(ack),          32'd1);
        check("t2_cs_lo", 32'(m_chipselect), 32'd0);
        wait_acks(target, "t2_done");
        drop(0);

        // SET 0x0F then CLEAR 0x05: 0xA5 -> 0xAF -> 0xAA
        do_op(1, OP_SET,   8'h0F);
        do_op(2, OP_CLEAR, 8'h05);

        // All four held; last grant was 2, so service order is 3,0,1,2,3
        target = ack_count + 5;
        for (int i = 0; i < N_REQ; i++) post(i, OP_WRITE, 8'(1 << i));
        exp_op(3, OP_WRITE, 8'h08);
        exp_op(0, OP_WRITE, 8'h01);
        exp_op(1, OP_WRITE, 8'h02);
        exp_op(2, OP_WRITE, 8'h04);
        exp_op(3, OP_WRITE, 8'h08);
        wait_acks(target, "t4_all_held");
        // Only 0 and 3 held: alternate 0,3,0,3
        drop(1);
        drop(2);
        target = ack_count + 4;
        exp_op(0, OP_WRITE, 8'h01);
        exp_op(3, OP_WRITE, 8'h08);
        exp_op(0, OP_WRITE, 8'h01);
        exp_op(3, OP_WRITE, 8'h08);
        wait_acks(target, "t4_pair_held");
        drop(0);
        drop(3);

        // WRITE 0x3C, READ it back, then a WRITE must not disturb rdata
        do_op(0, OP_WRITE, 8'h3C);
        do_op(2, OP_READ,  8'h00);
        do_op(1, OP_WRITE, 8'h55);
        check("t5_rdata_held", 32'(rdata), 32'h3C);

        // Reset during ISSUE: write already presented stands, no ack
        post(1, OP_WRITE, 8'h11);
        exp_bus(OP_WRITE, 8'h11);
        tick();
        check("t6_in_issue", 32'(m_chipselect), 32'd1);
        reset_n = 1'b0;
        tick();
        check("t6_rst_busy",  32'(busy),         32'd0);
        check("t6_rst_cs",    32'(m_chipselect), 32'd0);
        check("t6_rst_ack",   32'(ack),          32'd0);
        check("t6_rst_rdata", 32'(rdata),        32'd0);
        model_rd = 8'h00;
        tick();
        reset_n = 1'b1;
        // Requesters 1 and 2 held; requester 1 wins first after reset
        target = ack_count + 1;
        post(2, OP_SET, 8'h80);
        exp_op(1, OP_WRITE, 8'h11);
        exp_op(2, OP_SET,   8'h80);
        wait_acks(target, "t6_first");
        drop(1);
        wait_acks(target + 1, "t6_second");
        drop(2);

        repeat (4) tick();
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        check("final_out_port",    32'(pio_out),      32'h91);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
